// File: rtl/seq_det_pkg.sv
// Shared defaults and bit-order convention for the serial sequence detectors.
package seq_det_pkg;

    localparam int             DEF_SEQ_LEN     = 3;
    localparam logic [2:0]     DEF_RST_PATTERN = 3'b101;
    localparam int             DEF_CNT_W       = 8;

    // Patterns are written MSB first: the MSB is the oldest bit received.
    localparam bit             PAT_MSB_FIRST   = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q = cnt_r;

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with overlap control, runtime pattern
// reload and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN     = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] RST_PATTERN = SEQ_LEN'(DEF_RST_PATTERN),
    parameter int                 CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in,
    input  logic               ovl_en,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int               FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] hist_r;
    logic [SEQ_LEN-1:0] pat_r;
    logic [FILL_W-1:0]  fill_r;
    logic               dout_r;

    logic [SEQ_LEN-1:0] hist_next_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic               match_s;

    // Post-shift history/fill and the match decision for this sample.
    always_comb begin
        hist_next_s = hist_r;
        fill_inc_s  = fill_r;
        match_s     = 1'b0;
        if (PAT_MSB_FIRST) begin
            hist_next_s = {hist_r[SEQ_LEN-2:0], din};
        end else begin
            hist_next_s = {din, hist_r[SEQ_LEN-1:1]};
        end
        if (fill_r == FILL_FULL) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + FILL_W'(1);
        end
        if (din_valid && !pat_load && (fill_inc_s == FILL_FULL) && (hist_next_s == pat_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // History, fill, pattern and Moore match flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r <= {SEQ_LEN{1'b0}};
            fill_r <= {FILL_W{1'b0}};
            pat_r  <= RST_PATTERN;
            dout_r <= 1'b0;
        end else if (pat_load) begin
            hist_r <= hist_r;
            fill_r <= {FILL_W{1'b0}};
            pat_r  <= pat_in;
            dout_r <= 1'b0;
        end else if (din_valid) begin
            hist_r <= hist_next_s;
            // Non-overlapping mode restarts the fill so no bit is reused.
            fill_r <= (match_s && !ovl_en) ? {FILL_W{1'b0}} : fill_inc_s;
            pat_r  <= pat_r;
            dout_r <= match_s;
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
            pat_r  <= pat_r;
            dout_r <= 1'b0;
        end
    end

    assign dout = dout_r;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match_s),
        .clr (cnt_clr),
        .q   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default instance plus a CNT_W=2
// instance sharing the same stimulus.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       ovl_en;
    logic       cnt_clr;
    logic       dout;
    logic [7:0] match_cnt;
    logic       dout2;
    logic [1:0] match_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .ovl_en(ovl_en),
        .cnt_clr(cnt_clr), .dout(dout), .match_cnt(match_cnt)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .ovl_en(ovl_en),
        .cnt_clr(cnt_clr), .dout(dout2), .match_cnt(match_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample one bit, then look at dout one step after the edge.
    task automatic send(input logic b, input logic exp_dout, input string tag);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        chk(tag, {31'd0, dout}, {31'd0, exp_dout});
    endtask

    task automatic gap(input string tag);
        din_valid = 1'b0;
        din       = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, {31'd0, dout}, 32'd0);
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst = 1'b0;
        #3;
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0;
        pat_in = 3'b000; ovl_en = 1'b1; cnt_clr = 1'b0;

        // Reset and defaults
        repeat (3) @(posedge clk);
        #1;
        chk("in_rst_dout", {31'd0, dout}, 32'd0);
        chk("in_rst_cnt", {24'd0, match_cnt}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_dout", {31'd0, dout}, 32'd0);
        chk("post_rst_cnt", {24'd0, match_cnt}, 32'd0);
        send(1'b1, 1'b0, "def_b0");
        send(1'b0, 1'b0, "def_b1");
        send(1'b1, 1'b1, "def_b2");
        chk("def_cnt", {24'd0, match_cnt}, 32'd1);
        gap("def_after");

        // Overlapping
        pulse_reset();
        ovl_en = 1'b1;
        send(1'b1, 1'b0, "ovl_0");
        send(1'b0, 1'b0, "ovl_1");
        send(1'b1, 1'b1, "ovl_2");
        send(1'b0, 1'b0, "ovl_3");
        send(1'b1, 1'b1, "ovl_4");
        chk("ovl_cnt", {24'd0, match_cnt}, 32'd2);

        // Non-overlapping
        pulse_reset();
        ovl_en = 1'b0;
        send(1'b1, 1'b0, "novl_0");
        send(1'b0, 1'b0, "novl_1");
        send(1'b1, 1'b1, "novl_2");
        send(1'b0, 1'b0, "novl_3");
        send(1'b1, 1'b0, "novl_4");
        chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

        // Valid gaps
        pulse_reset();
        ovl_en = 1'b1;
        send(1'b1, 1'b0, "gap_b0");
        gap("gap_g0");
        send(1'b0, 1'b0, "gap_b1");
        gap("gap_g1");
        gap("gap_g2");
        send(1'b1, 1'b1, "gap_b2");
        chk("gap_cnt", {24'd0, match_cnt}, 32'd1);

        // Pattern reload
        pulse_reset();
        send(1'b1, 1'b0, "rel_b0");
        send(1'b0, 1'b0, "rel_b1");
        pat_load = 1'b1;
        pat_in   = 3'b110;
        send(1'b1, 1'b0, "rel_load");
        pat_load = 1'b0;
        send(1'b1, 1'b0, "rel_p0");
        send(1'b1, 1'b0, "rel_p1");
        send(1'b0, 1'b1, "rel_p2");
        send(1'b1, 1'b0, "rel_q0");
        send(1'b0, 1'b0, "rel_q1");
        send(1'b1, 1'b0, "rel_q2");
        chk("rel_cnt", {24'd0, match_cnt}, 32'd1);

        // Saturation and clear-vs-match
        pulse_reset();
        send(1'b1, 1'b0, "sat_a");
        send(1'b0, 1'b0, "sat_b");
        send(1'b1, 1'b1, "sat_m1");
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, "sat_z");
            send(1'b1, 1'b1, "sat_m");
        end
        chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
        chk("sat_cnt8", {24'd0, match_cnt}, 32'd5);
        send(1'b0, 1'b0, "clr_z");
        cnt_clr = 1'b1;
        send(1'b1, 1'b1, "clr_dout");
        cnt_clr = 1'b0;
        chk("clr_dout2", {31'd0, dout2}, 32'd1);
        chk("clr_cnt2", {30'd0, match_cnt2}, 32'd0);
        chk("clr_cnt8", {24'd0, match_cnt}, 32'd0);

        // Mid-operation asynchronous reset
        pulse_reset();
        send(1'b1, 1'b0, "mid_a");
        send(1'b0, 1'b0, "mid_b");
        send(1'b1, 1'b1, "mid_c");
        send(1'b0, 1'b0, "mid_d");
        chk("mid_pre_cnt", {24'd0, match_cnt}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_async_cnt", {24'd0, match_cnt}, 32'd0);
        chk("mid_async_dout", {31'd0, dout}, 32'd0);
        #2;
        rst = 1'b1;
        send(1'b1, 1'b0, "mid_r0");
        send(1'b0, 1'b0, "mid_r1");
        send(1'b1, 1'b1, "mid_r2");
        chk("mid_cnt", {24'd0, match_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
